pll_lock_supervisor: RTL

Supervises the TDC and SPI PLLs from the fabric side. It drives their asynchronous reset, receives their `locked` outputs, and qualifies lock. It releases `sys_ready` to downstream TDC and SPI logic only after every PLL has held lock continuously for a programmable time. On lock loss or timeout it re-arms, and re-resets the PLLs when needed. It runs on the board reference clock, upstream of the multiphase clock distribution.

---
 rtl/pll_sup_pkg.sv | 19 +
 rtl/sync_bits.sv | 32 +++
 rtl/pll_lock_supervisor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3
  } pll_sup_state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
module sync_bits #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q_reg <= '0;
          else     q_reg <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) q_reg <= '0;
          else     q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign q = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL reset and qualifies lock before releasing sys_ready.
// Optional loss counter built only when PLL_LOSS_COUNT_EN is defined.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int N_PLL          = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int ARESET_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PLL-1:0]      locked_async,
  input  logic                  force_relock,
  output logic                  pll_areset,
  output logic                  sys_ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [2:0]            state_dbg
);

  localparam int MAX_CNT = max3(ARESET_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [N_PLL-1:0] locked_sync;
  logic             all_locked;

  pll_sup_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lost_next;
  logic             pll_areset_reg, sys_ready_reg, lock_lost_reg;

  sync_bits #(
    .WIDTH (N_PLL),
    .DEPTH (SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked_async),
    .q   (locked_sync)
  );

  assign all_locked = &locked_sync;

  // force_relock overrides everything, including a simultaneous lock loss.
  always_comb begin
    state_next = state_reg;
    lost_next  = 1'b0;
    if (force_relock) begin
      state_next = PLL_RST;
    end else begin
      case (state_reg)
        PLL_RST: begin
          if (cnt_reg == ARESET_LAST) state_next = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (all_locked)                  state_next = STABLE;
          else if (cnt_reg == TIMEOUT_LAST) state_next = PLL_RST;
        end
        STABLE: begin
          if (!all_locked)                state_next = WAIT_LOCK;
          else if (cnt_reg == STABLE_LAST) state_next = READY;
        end
        READY: begin
          if (!all_locked) begin
            state_next = WAIT_LOCK;
            lost_next  = 1'b1;
          end
        end
        default: state_next = PLL_RST;
      endcase
    end
  end

  // READY has no timed exit, so the counter is parked there to avoid wrapping.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    if (force_relock || (state_next != state_reg)) cnt_next = '0;
    else if (state_reg == READY)                   cnt_next = cnt_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= PLL_RST;
      cnt_reg        <= '0;
      pll_areset_reg <= 1'b1;
      sys_ready_reg  <= 1'b0;
      lock_lost_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      pll_areset_reg <= (state_next == PLL_RST);
      sys_ready_reg  <= (state_next == READY);
      lock_lost_reg  <= lost_next;
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   loss_count_reg <= '0;
    else if (lost_next && (loss_count_reg != '1)) loss_count_reg <= loss_count_reg + 1'b1;
  end

  assign loss_count = loss_count_reg;
`else
  assign loss_count = '0;
`endif

  assign pll_areset = pll_areset_reg;
  assign sys_ready  = sys_ready_reg;
  assign lock_lost  = lock_lost_reg;
  assign state_dbg  = state_reg;

endmodule
